// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_pkg : state encoding and default sizing shared by the PWM blocks      |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
package pwm_pkg;

  localparam int c_CNT_W   = 8;
  localparam int c_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

endpackage
`default_nettype wire

// File: rtl/pwm_edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_edge_sync : 2-flop synchroniser plus delay flop with edge detection  |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module pwm_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_capture : measures high time and period of a PWM input, flags stuck  |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = c_CNT_W,
  parameter int TIMEOUT = c_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] on_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] c_TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;

  logic sync_level, sync_rise, sync_fall;

  pwm_edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pwm_in),
    .level (sync_level),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] on_time_q, on_time_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;

  logic [CNT_W-1:0] hi_inc, per_inc;
  logic             timeout_hit;

  // Saturating increments: a fall landing exactly on the timeout count must not wrap.
  always_comb begin
    hi_inc      = (hi_cnt_q == c_CNT_MAX) ? hi_cnt_q : hi_cnt_q + c_CNT_ONE;
    per_inc     = (per_cnt_q == c_CNT_MAX) ? per_cnt_q : per_cnt_q + c_CNT_ONE;
    timeout_hit = (per_cnt_q == c_TIMEOUT_CNT);
  end

  always_comb begin
    state_d       = state_q;
    hi_cnt_d      = hi_cnt_q;
    per_cnt_d     = per_cnt_q;
    on_time_d     = on_time_q;
    period_d      = period_q;
    meas_valid_d  = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    if (!en) begin
      state_d   = ST_IDLE;
      hi_cnt_d  = '0;
      per_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hi_cnt_d  = '0;
          per_cnt_d = '0;
          if (sync_rise) begin
            state_d   = ST_HIGH;
            hi_cnt_d  = c_CNT_ONE;
            per_cnt_d = c_CNT_ONE;
            stuck_d   = 1'b0;
          end
        end

        ST_HIGH: begin
          if (sync_fall) begin
            state_d   = ST_LOW;
            per_cnt_d = per_inc;
          end else if (timeout_hit) begin
            state_d       = ST_IDLE;
            hi_cnt_d      = '0;
            per_cnt_d     = '0;
            stuck_d       = 1'b1;
            stuck_level_d = sync_level;
          end else begin
            hi_cnt_d  = hi_inc;
            per_cnt_d = per_inc;
          end
        end

        ST_LOW: begin
          // A rise on the timeout cycle still closes a valid period.
          if (sync_rise) begin
            state_d      = ST_HIGH;
            on_time_d    = hi_cnt_q;
            period_d     = per_cnt_q;
            meas_valid_d = 1'b1;
            hi_cnt_d     = c_CNT_ONE;
            per_cnt_d    = c_CNT_ONE;
          end else if (timeout_hit) begin
            state_d       = ST_IDLE;
            hi_cnt_d      = '0;
            per_cnt_d     = '0;
            stuck_d       = 1'b1;
            stuck_level_d = sync_level;
          end else begin
            per_cnt_d = per_inc;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          hi_cnt_d  = '0;
          per_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hi_cnt_q      <= '0;
      per_cnt_q     <= '0;
      on_time_q     <= '0;
      period_q      <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_cnt_q      <= hi_cnt_d;
      per_cnt_q     <= per_cnt_d;
      on_time_q     <= on_time_d;
      period_q      <= period_d;
      meas_valid_q  <= meas_valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign on_time     = on_time_q;
  assign period      = period_q;
  assign meas_valid  = meas_valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_capture : directed vector table plus corner sequences             |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] on_time, period;
  logic       meas_valid, stuck, stuck_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int double_pulse = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [7:0] on;
    logic [7:0] per;
    int         cyc;
  } meas_t;

  typedef struct {
    int         hi;
    int         lo;
    int         n;
    logic [7:0] exp_on;
    logic [7:0] exp_per;
  } vec_t;

  meas_t q[$];
  vec_t  vecs[6];

  pwm_capture #(.CNT_W(8), .TIMEOUT(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .pwm_in      (pwm_in),
    .on_time     (on_time),
    .period      (period),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    meas_t m;
    if (meas_valid) begin
      m.on  = on_time;
      m.per = period;
      m.cyc = cyc;
      q.push_back(m);
    end
    if (meas_valid && prev_valid) double_pulse <= double_pulse + 1;
    prev_valid <= meas_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] last_on();
    logic [7:0] none = 8'hxx;
    if (q.size() == 0) return none;
    return q[q.size()-1].on;
  endfunction

  function automatic logic [7:0] last_per();
    logic [7:0] none = 8'hxx;
    if (q.size() == 0) return none;
    return q[q.size()-1].per;
  endfunction

  function automatic int last_gap();
    if (q.size() < 2) return -1;
    return q[q.size()-1].cyc - q[q.size()-2].cyc;
  endfunction

  // Number of recorded pulses matching neither allowed (on, period) pair.
  function automatic int bad_count(input logic [7:0] on_a, input logic [7:0] per_a,
                                   input logic [7:0] on_b, input logic [7:0] per_b);
    int bad = 0;
    foreach (q[k]) begin
      if (!((q[k].on === on_a && q[k].per === per_a) ||
            (q[k].on === on_b && q[k].per === per_b))) bad++;
    end
    return bad;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    pwm_in = 1'b0;
    en     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_periods(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      repeat (hi) @(negedge clk);
      pwm_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic close_rise();
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{30,  70,  3, 8'd30,  8'd100};
    vecs[1] = '{60,  40,  3, 8'd60,  8'd100};
    vecs[2] = '{1,   1,   10, 8'd1,  8'd2};
    vecs[3] = '{2,   3,   5, 8'd2,   8'd5};
    vecs[4] = '{1,   254, 2, 8'd1,   8'd255};
    vecs[5] = '{254, 1,   2, 8'd254, 8'd255};

    reset = 1'b1; en = 1'b1; pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {on_time, period, meas_valid, stuck, stuck_level}, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      q.delete();
      run_periods(vecs[i].hi, vecs[i].lo, vecs[i].n);
      close_rise();
      check($sformatf("v%0d_valid_count", i), q.size(), vecs[i].n);
      check($sformatf("v%0d_bad_pulses", i),
            bad_count(vecs[i].exp_on, vecs[i].exp_per, vecs[i].exp_on, vecs[i].exp_per), 0);
      check($sformatf("v%0d_on_time", i), last_on(), vecs[i].exp_on);
      check($sformatf("v%0d_period", i), last_per(), vecs[i].exp_per);
      check($sformatf("v%0d_valid_gap", i), last_gap(), vecs[i].hi + vecs[i].lo);
      check($sformatf("v%0d_stuck", i), stuck, 0);
    end

    // Duty change mid-stream.
    do_reset();
    q.delete();
    run_periods(30, 70, 3);
    run_periods(60, 40, 3);
    check("duty_valid_count", q.size(), 5);
    check("duty_mixed_pulses", bad_count(8'd30, 8'd100, 8'd60, 8'd100), 0);
    check("duty_on_time", last_on(), 60);
    check("duty_period", last_per(), 100);

    // Stuck high: timeout fires exactly when per_cnt reaches 255.
    q.delete();
    pwm_in = 1'b1;
    repeat (257) @(negedge clk);
    check("stuck_hi_before_timeout", stuck, 0);
    @(negedge clk);
    check("stuck_hi_set", stuck, 1);
    check("stuck_hi_level", stuck_level, 1);
    repeat (43) @(negedge clk);
    check("stuck_hi_held", stuck, 1);
    check("stuck_hi_outputs_kept", {on_time, period}, {8'd60, 8'd100});
    check("stuck_hi_valid_count", q.size(), 1);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    check("stuck_hi_fall_ignored", stuck, 1);
    pwm_in = 1'b1;
    repeat (20) @(negedge clk);
    check("stuck_cleared_by_rise", stuck, 0);
    check("stuck_clear_no_valid", q.size(), 1);

    // Stuck low.
    pwm_in = 1'b0;
    repeat (300) @(negedge clk);
    check("stuck_lo_set", stuck, 1);
    check("stuck_lo_level", stuck_level, 0);
    check("stuck_lo_outputs_kept", {on_time, period}, {8'd60, 8'd100});
    check("stuck_lo_valid_count", q.size(), 1);

    // Reset in the middle of a high phase.
    q.delete();
    run_periods(30, 70, 2);
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_reset_valid_count", q.size(), 2);
    reset  = 1'b1;
    pwm_in = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", {on_time, period, meas_valid, stuck, stuck_level}, 0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    repeat (10) @(negedge clk);
    run_periods(40, 60, 2);
    close_rise();
    check("post_reset_valid_count", q.size(), 2);
    check("post_reset_bad_pulses", bad_count(8'd40, 8'd100, 8'd40, 8'd100), 0);

    // Enable dropped during a period.
    q.delete();
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b0;
    run_periods(10, 10, 2);
    repeat (10) @(negedge clk);
    check("en_off_no_valid", q.size(), 0);
    check("en_off_outputs_held", {on_time, period, stuck}, {8'd40, 8'd100, 1'b0});
    en = 1'b1;
    repeat (5) @(negedge clk);
    run_periods(25, 75, 2);
    close_rise();
    check("en_on_valid_count", q.size(), 2);
    check("en_on_bad_pulses", bad_count(8'd25, 8'd100, 8'd25, 8'd100), 0);

    check("no_back_to_back_valid", double_pulse, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
